// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, write-back
// sources, trap causes, FSM states and the decoder's output bundle.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_IL    = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [1:0] WSRC_ALU  = 2'b00;
  localparam logic [1:0] WSRC_LOAD = 2'b01;
  localparam logic [1:0] WSRC_IMM  = 2'b10;
  localparam logic [1:0] WSRC_PC4  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IFETCH  = 2'b10;
  localparam logic [1:0] CAUSE_DATA    = 2'b11;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;

  typedef struct packed {
    logic       illegal;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       is_jump;
    logic       alu_src_sel_1;
    logic       alu_src_sel_2;
    logic [1:0] reg_w_src_sel;
    logic [3:0] alu_op;
    logic [2:0] funct3;
  } dec_t;

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Pure-combinational decode of the latched instruction into datapath selects,
// ALU op and instruction class; the FSM decides when any of it takes effect.
module rv32i_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [2:0] funct3;
  logic       unused_ir_bits;

  assign funct3         = ir[14:12];
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec        = '0;
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    case (ir[6:0])
      OPC_R: begin
        dec.alu_op = {ir[30], funct3};
      end
      OPC_I: begin
        dec.alu_src_sel_2 = 1'b1;
        // Only SRAI carries funct7[5]; in other I-types that bit is immediate.
        dec.alu_op = {(funct3 == 3'b101) & ir[30], funct3};
      end
      OPC_IL: begin
        dec.is_load       = 1'b1;
        dec.alu_src_sel_2 = 1'b1;
        dec.reg_w_src_sel = WSRC_LOAD;
      end
      OPC_S: begin
        dec.is_store      = 1'b1;
        dec.alu_src_sel_2 = 1'b1;
      end
      OPC_B: begin
        dec.is_branch = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_src_sel_2 = 1'b1;
        dec.reg_w_src_sel = WSRC_IMM;
      end
      OPC_AUIPC: begin
        dec.alu_src_sel_1 = 1'b1;
        dec.alu_src_sel_2 = 1'b1;
      end
      OPC_JAL: begin
        dec.is_jump       = 1'b1;
        dec.alu_src_sel_1 = 1'b1;
        dec.alu_src_sel_2 = 1'b1;
        dec.reg_w_src_sel = WSRC_PC4;
      end
      OPC_JALR: begin
        dec.is_jump       = 1'b1;
        dec.alu_src_sel_2 = 1'b1;
        dec.reg_w_src_sel = WSRC_PC4;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/write-back
// with memory handshakes, bus timeout, illegal-opcode trap and retire counter.
module multicycle_control_unit
  import rv32i_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int INSTRET_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ack,
  input  logic [31:0]           instr_code,
  input  logic                  d_ack,
  output logic                  i_req,
  output logic                  d_req,
  output logic                  d_we,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  regfile_we,
  output logic                  alu_src_sel_1,
  output logic                  alu_src_sel_2,
  output logic [1:0]            reg_w_src_sel,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            comp_control,
  output logic [2:0]            size_control,
  output logic                  branch,
  output logic                  jal,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [INSTRET_W-1:0]  instret
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
    WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                 state;
  logic [31:0]            ir;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [INSTRET_W-1:0]   instret_q;
  logic [1:0]             trap_cause_q;
  logic                   timeout_hit;
  dec_t                   dec;

  rv32i_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // The cycle that completes the wait budget traps unless its ack arrives.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      ir           <= '0;
      wait_cnt     <= '0;
      instret_q    <= '0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      if (pc_we) instret_q <= instret_q + INSTRET_W'(1);
      // NOTE: non-blocking, so the increments below override this clear (last NBA wins).
      wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (i_ack) begin
            ir    <= instr_code;
            state <= DECODE;
          end else if (timeout_hit) begin
            trap_cause_q <= CAUSE_IFETCH;
            state        <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DECODE: begin
          if (dec.illegal) begin
            trap_cause_q <= CAUSE_ILLEGAL;
            state        <= TRAP;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (dec.is_branch)                   state <= FETCH;
          else if (dec.is_load || dec.is_store) state <= MEM;
          else                                  state <= WB;
        end
        MEM: begin
          if (d_ack) begin
            state <= dec.is_store ? FETCH : WB;
          end else if (timeout_hit) begin
            trap_cause_q <= CAUSE_DATA;
            state        <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes come from registered state and IR only; acks just qualify the edge.
  always_comb begin
    i_req         = 1'b0;
    d_req         = 1'b0;
    d_we          = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    regfile_we    = 1'b0;
    alu_src_sel_1 = 1'b0;
    alu_src_sel_2 = 1'b0;
    reg_w_src_sel = WSRC_ALU;
    alu_control   = '0;
    comp_control  = '0;
    size_control  = '0;
    branch        = 1'b0;
    jal           = 1'b0;
    trap          = 1'b0;
    trap_cause    = CAUSE_NONE;
    instret       = '0;
    if (!rst) begin
      trap       = (state == TRAP);
      trap_cause = trap_cause_q;
      instret    = instret_q;
      if (state inside {EXECUTE, MEM, WB}) begin
        alu_src_sel_1 = dec.alu_src_sel_1;
        alu_src_sel_2 = dec.alu_src_sel_2;
        reg_w_src_sel = dec.reg_w_src_sel;
        alu_control   = ALU_CTRL_W'(dec.alu_op);
        if (dec.is_load || dec.is_store) size_control = dec.funct3;
      end
      case (state)
        FETCH: begin
          i_req = 1'b1;
          ir_we = i_ack;
        end
        EXECUTE: begin
          branch = dec.is_branch;
          jal    = dec.is_jump;
          pc_we  = dec.is_branch;
          if (dec.is_branch) comp_control = dec.funct3;
        end
        MEM: begin
          d_req = 1'b1;
          d_we  = dec.is_store;
          pc_we = dec.is_store & d_ack;
        end
        WB: begin
          jal        = dec.is_jump;
          regfile_we = 1'b1;
          pc_we      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: table of instructions with a
// retire scoreboard, plus hand-written trap, timeout and mid-instruction reset runs.
module tb_multicycle_control_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ack, d_ack;
  logic [31:0] instr_code;
  logic        i_req, d_req, d_we, ir_we, pc_we, regfile_we;
  logic        alu_src_sel_1, alu_src_sel_2;
  logic [1:0]  reg_w_src_sel;
  logic [3:0]  alu_control;
  logic [2:0]  comp_control, size_control;
  logic        branch, jal, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .ALU_CTRL_W  (4),
    .TIMEOUT_CYC (TIMEOUT),
    .INSTRET_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ack         (i_ack),
    .instr_code    (instr_code),
    .d_ack         (d_ack),
    .i_req         (i_req),
    .d_req         (d_req),
    .d_we          (d_we),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .regfile_we    (regfile_we),
    .alu_src_sel_1 (alu_src_sel_1),
    .alu_src_sel_2 (alu_src_sel_2),
    .reg_w_src_sel (reg_w_src_sel),
    .alu_control   (alu_control),
    .comp_control  (comp_control),
    .size_control  (size_control),
    .branch        (branch),
    .jal           (jal),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .instret       (instret)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          iw;       // i_ack delay in FETCH cycles
    int          dw;       // d_ack delay in MEM cycles
    bit          noise;    // drive acks while the matching req is low
    int          cyc;      // FETCH..retire cycles
    bit          rf;
    int          dreq;
    bit          dwe;
    bit          br;
    bit          jl;
    logic [1:0]  wsrc;
    bit          chk_sel;
    bit          s1;
    bit          s2;
    bit          chk_alu;
    logic [3:0]  alu;
    bit          chk_f3;
    logic [2:0]  f3;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_instret;
  vec_t vecs[13];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(string name, logic [31:0] instr, int iw, int dw, bit noise,
                              int cyc, bit rf, int dreq, bit dwe, bit br, bit jl,
                              logic [1:0] wsrc, bit chk_sel, bit s1, bit s2,
                              bit chk_alu, logic [3:0] alu, bit chk_f3, logic [2:0] f3);
    vec_t v;
    v.name = name;   v.instr = instr; v.iw = iw;   v.dw = dw;     v.noise = noise;
    v.cyc = cyc;     v.rf = rf;       v.dreq = dreq; v.dwe = dwe; v.br = br; v.jl = jl;
    v.wsrc = wsrc;   v.chk_sel = chk_sel; v.s1 = s1; v.s2 = s2;
    v.chk_alu = chk_alu; v.alu = alu; v.chk_f3 = chk_f3; v.f3 = f3;
    return v;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    i_ack = 1'b0;
    d_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_instret = 0;
  endtask

  // Drives one instruction from its FETCH cycle; the retire cycle pops the scoreboard.
  task automatic run_vec(input vec_t v);
    int   cyc = 0, icnt = 0, dcnt = 0, rfc = 0;
    bit   dwe = 0, br = 0, jl = 0, done = 0;
    bit   rf_r = 0, dwe_r = 0, s1_r = 0, s2_r = 0;
    logic [1:0]  wsrc_r = '0;
    logic [3:0]  alu_r = '0;
    logic [2:0]  size_r = '0, comp_r = '0;
    logic [31:0] ir_r = '0;
    vec_t e;
    sb.push_back(v);
    while (!done && cyc < 40) begin
      @(negedge clk);
      instr_code = v.instr;
      i_ack = i_req ? (icnt == v.iw) : v.noise;
      d_ack = d_req ? (dcnt == v.dw) : v.noise;
      #1;
      cyc++;
      if (i_req) icnt++;
      if (d_req) dcnt++;
      if (regfile_we) rfc++;
      dwe |= d_we;
      br  |= branch;
      jl  |= jal;
      if (pc_we) begin
        done = 1;
        rf_r = regfile_we;  dwe_r = d_we;  s1_r = alu_src_sel_1;  s2_r = alu_src_sel_2;
        wsrc_r = reg_w_src_sel;  alu_r = alu_control;
        size_r = size_control;  comp_r = comp_control;  ir_r = instret;
      end
    end
    if (!done) begin
      check({v.name, ":retire_timeout"}, 32'(cyc), 32'(v.cyc));
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({e.name, ":cycles"},     32'(cyc),  32'(e.cyc));
      check({e.name, ":ireq_cyc"},   32'(icnt), 32'(e.iw + 1));
      check({e.name, ":rf_we_cnt"},  32'(rfc),  32'(e.rf));
      check({e.name, ":rf_at_ret"},  32'(rf_r), 32'(e.rf));
      check({e.name, ":dreq_cyc"},   32'(dcnt), 32'(e.dreq));
      check({e.name, ":d_we"},       32'(dwe),  32'(e.dwe));
      check({e.name, ":d_we_at_ret"},32'(dwe_r),32'(e.dwe));
      check({e.name, ":branch"},     32'(br),   32'(e.br));
      check({e.name, ":jal"},        32'(jl),   32'(e.jl));
      check({e.name, ":instret"},    ir_r,      32'(exp_instret));
      if (e.rf)      check({e.name, ":wsrc"}, 32'(wsrc_r), 32'(e.wsrc));
      if (e.chk_sel) check({e.name, ":sel"},  32'({s1_r, s2_r}), 32'({e.s1, e.s2}));
      if (e.chk_alu) check({e.name, ":alu"},  32'(alu_r), 32'(e.alu));
      if (e.chk_f3 && e.dreq > 0) check({e.name, ":size"}, 32'(size_r), 32'(e.f3));
      if (e.chk_f3 && e.br)       check({e.name, ":comp"}, 32'(comp_r), 32'(e.f3));
      exp_instret++;
    end
  endtask

  // Runs from FETCH until trap rises, then confirms the trap is sticky and silent.
  task automatic run_to_trap(input string name, input logic [31:0] instr, input bit i_never,
                             input int exp_cyc, input logic [1:0] exp_cause,
                             input int exp_ireq, input int exp_dreq);
    int cyc = 0, icnt = 0, dcnt = 0, bad = 0, held = 0;
    bit seen = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      instr_code = instr;
      i_ack = !i_never;
      d_ack = 1'b0;
      #1;
      cyc++;
      if (trap) seen = 1;
      else begin
        if (i_req) icnt++;
        if (d_req) dcnt++;
        if (pc_we || regfile_we) bad++;
      end
    end
    check({name, ":trap_cycle"}, 32'(cyc),  32'(exp_cyc));
    check({name, ":cause"},      32'(trap_cause), 32'(exp_cause));
    check({name, ":ireq_cyc"},   32'(icnt), 32'(exp_ireq));
    check({name, ":dreq_cyc"},   32'(dcnt), 32'(exp_dreq));
    check({name, ":no_write"},   32'(bad),  32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_ack = 1'b1;
      d_ack = 1'b1;
      #1;
      if (!trap || trap_cause !== exp_cause || i_req || d_req || pc_we || regfile_we || ir_we)
        held++;
    end
    check({name, ":sticky_quiet"}, 32'(held), 32'd0);
    check({name, ":instret_hold"}, instret, 32'(exp_instret));
  endtask

  function automatic logic [31:0] all_outs();
    return {8'h0, i_req, d_req, d_we, ir_we, pc_we, regfile_we, alu_src_sel_1, alu_src_sel_2,
            reg_w_src_sel, alu_control, comp_control, size_control, branch, jal, trap,
            trap_cause};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  guard;
    vec_t add_v, lw_v;

    vecs[0]  = mk("add",        32'h002081B3, 0, 0, 1, 4, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 4'b0000, 0, 3'b000);
    vecs[1]  = mk("lw_wait3",   32'h0000A183, 0, 3, 0, 8, 1, 4, 0, 0, 0, 2'b01, 1, 0, 1, 0, 4'b0000, 1, 3'b010);
    vecs[2]  = mk("sw",         32'h0020A023, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2'b00, 1, 0, 1, 0, 4'b0000, 1, 3'b010);
    vecs[3]  = mk("beq",        32'h00208463, 0, 0, 1, 3, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 1, 3'b000);
    vecs[4]  = mk("addi_iw2",   32'h00500093, 2, 0, 0, 6, 1, 0, 0, 0, 0, 2'b00, 1, 0, 1, 1, 4'b0000, 0, 3'b000);
    vecs[5]  = mk("sub",        32'h402081B3, 0, 0, 1, 4, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 4'b1000, 0, 3'b000);
    vecs[6]  = mk("srai",       32'h40335293, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 1, 0, 1, 1, 4'b1101, 0, 3'b000);
    vecs[7]  = mk("lui",        32'h123453B7, 0, 0, 1, 4, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 4'b0000, 0, 3'b000);
    vecs[8]  = mk("jal",        32'h008000EF, 0, 0, 0, 4, 1, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 4'b0000, 0, 3'b000);
    vecs[9]  = mk("auipc",      32'h00001117, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0, 4'b0000, 0, 3'b000);
    vecs[10] = mk("lw",         32'h0000A183, 0, 0, 1, 5, 1, 1, 0, 0, 0, 2'b01, 1, 0, 1, 0, 4'b0000, 1, 3'b010);
    vecs[11] = mk("jalr",       32'h00008067, 0, 0, 0, 4, 1, 0, 0, 0, 1, 2'b11, 1, 0, 1, 0, 4'b0000, 0, 3'b000);
    vecs[12] = mk("sb_wait2",   32'h00208023, 0, 2, 1, 6, 0, 3, 1, 0, 0, 2'b00, 1, 0, 1, 0, 4'b0000, 1, 3'b000);
    add_v = vecs[0];
    lw_v  = vecs[1];

    rst        = 1'b1;
    i_ack      = 1'b1;
    d_ack      = 1'b1;
    instr_code = 32'h002081B3;
    @(negedge clk);
    #1;
    check("reset:outputs_zero", all_outs(), 32'd0);
    check("reset:instret_zero", instret, 32'd0);
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);
    check("table:scoreboard_empty", 32'(sb.size()), 32'd0);

    do_reset();
    run_to_trap("illegal_7f", 32'h0000007F, 1'b0, 3, 2'b01, 1, 0);

    do_reset();
    run_to_trap("ifetch_timeout", 32'h002081B3, 1'b1, 5, 2'b10, 4, 0);

    do_reset();
    run_to_trap("data_timeout", 32'h0000A183, 1'b0, 8, 2'b11, 1, 4);

    // New run: retire one ADD, then reset while a load sits in MEM.
    do_reset();
    run_vec(add_v);
    guard = 0;
    do begin
      @(negedge clk);
      instr_code = lw_v.instr;
      i_ack = 1'b1;
      d_ack = 1'b0;
      #1;
      guard++;
    end while (!d_req && guard < 10);
    check("mid_mem:reached_mem", 32'(d_req), 32'd1);
    check("mid_mem:instret_before", instret, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_mem:outputs_zero_in_rst", all_outs(), 32'd0);
    check("mid_mem:instret_zero_in_rst", instret, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    i_ack = 1'b0;
    d_ack = 1'b1;
    @(negedge clk);
    #1;
    check("mid_mem:fetch_after_rst", 32'({i_req, d_req, regfile_we, pc_we, trap}), 32'b10000);
    check("mid_mem:instret_cleared", instret, 32'd0);
    exp_instret = 0;
    run_vec(add_v);
    @(negedge clk);
    #1;
    check("mid_mem:instret_after_add", instret, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
